// File: rtl/tff_count_sequencer.sv
// rtl/tff_count_sequencer.sv - toggle-vector sequencer for a T-flip-flop counter bank
//
// Loads a start value into an external T-flip-flop bank purely by toggling,
// then counts up or down (modulo 2^WIDTH) until the bank reaches a captured
// terminal value, and pulses done the cycle after the terminal count.
//
// Optional feature macro: CNT_SEQ_RELOAD_EN (adds the reload port; when the
// captured reload bit is set the sequence restarts from LOAD after every
// terminal count instead of returning to IDLE).
//
// Ports:
//   C        clock, rising edge
//   R        synchronous active-high reset
//   start    begin a count (accepted only in IDLE)
//   stop     abort (honoured in LOAD and RUN)
//   dir      0 = up, 1 = down (captured with start)
//   load_val initial count (captured with start)
//   limit    terminal count (captured with start)
//   reload   restart after terminal (CNT_SEQ_RELOAD_EN builds only)
//   q        registered Q outputs of the bank
//   t        toggle vector to the bank (combinational)
//   busy     high while in LOAD or RUN (registered)
//   done     one-cycle pulse after the terminal count (registered)

module tff_count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
`ifdef CNT_SEQ_RELOAD_EN
    input  logic             reload,
`endif
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] load_r;
    logic [WIDTH-1:0] limit_r;
    logic             dir_r;
`ifdef CNT_SEQ_RELOAD_EN
    logic             reload_r;
`endif

    logic             capture;
    logic             done_set;
    logic [WIDTH-1:0] t_c;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;

    // Ripple toggle vectors: bit i toggles when every lower bit is 1 (up)
    // or every lower bit is 0 (down). Accumulators keep the chain acyclic.
    always_comb begin
        logic acc_up;
        logic acc_dn;
        up_t   = '0;
        dn_t   = '0;
        acc_up = 1'b1;
        acc_dn = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = acc_up;
            dn_t[i] = acc_dn;
            acc_up  = acc_up & q[i];
            acc_dn  = acc_dn & ~q[i];
        end
    end

    always_comb begin
        next_state = state;
        t_c        = '0;
        capture    = 1'b0;
        done_set   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    next_state = ST_IDLE;
                end else begin
                    // Toggle exactly the bits that differ so the bank lands on load_r.
                    t_c        = q ^ load_r;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    next_state = ST_IDLE;
                end else if (q == limit_r) begin
                    done_set   = 1'b1;
`ifdef CNT_SEQ_RELOAD_EN
                    next_state = reload_r ? ST_LOAD : ST_IDLE;
`else
                    next_state = ST_IDLE;
`endif
                end else begin
                    t_c = dir_r ? dn_t : up_t;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // Reset must silence the bank within the same cycle.
        if (R) begin
            t_c        = '0;
            next_state = ST_IDLE;
            capture    = 1'b0;
            done_set   = 1'b0;
        end
    end

    assign t = t_c;

    always_ff @(posedge C) begin
        if (R) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            load_r   <= '0;
            limit_r  <= '0;
            dir_r    <= 1'b0;
`ifdef CNT_SEQ_RELOAD_EN
            reload_r <= 1'b0;
`endif
        end else begin
            state <= next_state;
            busy  <= (next_state != ST_IDLE);
            done  <= done_set;
            if (capture) begin
                load_r   <= load_val;
                limit_r  <= limit;
                dir_r    <= dir;
`ifdef CNT_SEQ_RELOAD_EN
                reload_r <= reload;
`endif
            end
        end
    end

endmodule
